// File: rtl/m_serial_deframer.sv
// m_serial_deframer: one-bit-per-clock serial receiver.
// Frame: start 0, DATA_W data bits LSB-first, optional even parity bit, stop 1.
// The received word is held in a one-entry valid/ready buffer.
// Define DESER_PARITY_EN to add the even-parity bit and its check.
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | line idle, waiting for a 0 start bit
// ST_DATA   | sampling data bit cnt into the assembly register
// ST_PARITY | sampling the parity bit (parity build only)
// ST_STOP   | sampling the stop bit, deciding load/overrun/error
module m_serial_deframer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                valid_q, valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic                frame_good;
  logic                load;
`ifdef DESER_PARITY_EN
  logic                par_q, par_d;
`endif

  // Next-state, assembly and output-buffer decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    data_out_d  = data_out_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    frame_good  = 1'b0;
    load        = 1'b0;
`ifdef DESER_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!d_in) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        shreg_d[cnt_q] = d_in;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
`ifdef DESER_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
      ST_PARITY: begin
`ifdef DESER_PARITY_EN
        par_d = d_in;
`endif
        state_d = ST_STOP;
      end
      ST_STOP: begin
        // A 0 here is a framing error only; it never starts a new frame.
        state_d = ST_IDLE;
`ifdef DESER_PARITY_EN
        frame_good = d_in && !(^{shreg_q, par_q});
`else
        frame_good = d_in;
`endif
        if (!frame_good) begin
          frame_err_d = 1'b1;
        end else if (!valid_q || ready) begin
          load = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      data_out_d = shreg_q;
      valid_d    = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef DESER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef DESER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign data_out  = data_out_q;
  assign valid     = valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_m_serial_deframer.sv
// Testbench for m_serial_deframer: directed plan steps followed by random frames,
// checked every cycle against a frame-level reference model.
module tb_m_serial_deframer;

  localparam int DW = 8;
`ifdef DESER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          d_in;
  logic [DW-1:0] data_out;
  logic          valid;
  logic          ready;
  logic          busy;
  logic          frame_err;
  logic          overrun;

  m_serial_deframer #(.DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .d_in      (d_in),
    .data_out  (data_out),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: buffer contents plus expected pulses and busy.
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;
  logic          m_fe    = 1'b0;
  logic          m_ov    = 1'b0;
  logic          m_busy  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("valid", 32'(valid), 32'(m_valid));
    chk("data_out", 32'(data_out), 32'(m_data));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame_err", 32'(frame_err), 32'(m_fe));
    chk("overrun", 32'(overrun), 32'(m_ov));
  endtask

  // One clock: drive the line and ready, then apply the frame-level outcome.
  task automatic tick(input logic bit_v, input logic rdy, input bit stop_edge,
                      input bit good, input logic [DW-1:0] word, input bit busy_after);
    bit ld;
    d_in  = bit_v;
    ready = rdy;
    @(posedge clk);
    ld   = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
    if (stop_edge) begin
      if (!good) m_fe = 1'b1;
      else if (!m_valid || rdy) ld = 1'b1;
      else m_ov = 1'b1;
    end
    if (ld) begin
      m_valid = 1'b1;
      m_data  = word;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    m_busy = busy_after;
    #1;
    check_all();
  endtask

  task automatic reset_tick();
    reset = 1'b1;
    d_in  = 1'($urandom_range(0, 1));
    ready = 1'b1;
    @(posedge clk);
    m_valid = 1'b0;
    m_data  = '0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
    m_busy  = 1'b0;
    #1;
    check_all();
    reset = 1'b0;
  endtask

  function automatic logic pick(input logic fixed, input bit rnd);
    return rnd ? 1'($urandom_range(0, 1)) : fixed;
  endfunction

  task automatic idle(input int n, input logic rdy, input bit rnd);
    for (int i = 0; i < n; i++) tick(1'b1, pick(rdy, rnd), 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Full frame; pflip inverts the correct even-parity bit in parity builds.
  task automatic send_frame(input logic [DW-1:0] word, input logic stop, input bit pflip,
                            input logic rdy_body, input logic rdy_stop, input bit rnd);
    bit good;
    good = stop && !(PAR && pflip);
    tick(1'b0, pick(rdy_body, rnd), 1'b0, 1'b0, word, 1'b1);
    for (int i = 0; i < DW; i++) tick(word[i], pick(rdy_body, rnd), 1'b0, 1'b0, word, 1'b1);
    if (PAR) tick((^word) ^ pflip, pick(rdy_body, rnd), 1'b0, 1'b0, word, 1'b1);
    tick(stop, pick(rdy_stop, rnd), 1'b1, good, word, 1'b0);
  endtask

  task automatic send_partial(input logic [DW-1:0] word, input int nbits);
    tick(1'b0, 1'b0, 1'b0, 1'b0, word, 1'b1);
    for (int i = 0; i < nbits; i++) tick(word[i], 1'b0, 1'b0, 1'b0, word, 1'b1);
  endtask

  initial begin
    logic [DW-1:0] w;
    logic          s;
    bit            pf;
    reset = 1'b1;
    d_in  = 1'b1;
    ready = 1'b0;
    #2;
    reset_tick();
    reset_tick();

    // Idle line after reset.
    idle(20, 1'b0, 1'b1);

    // 0xA5 held with ready low, then popped.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    idle(2, 1'b0, 1'b0);

    // Bad stop bit, then a good frame straight after.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    idle(1, 1'b0, 1'b0);

    // Back-to-back with buffer full: second word overruns.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);

    // Buffer freed on the very stop edge: load without overrun.
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);

    // Reset mid-frame with a word buffered, then a clean frame.
    send_frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_partial(8'hFF, 4);
    reset_tick();
    idle(2, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b1, 1'b0);

    // Random frames, random ready, random gaps including back-to-back.
    for (int k = 0; k < 60; k++) begin
      w  = DW'($urandom);
      s  = ($urandom_range(0, 7) != 0);
      pf = ($urandom_range(0, 5) == 0);
      send_frame(w, s, pf, 1'b0, 1'b0, 1'b1);
      idle(int'($urandom_range(0, 2)), 1'b0, 1'b1);
    end
    idle(3, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/m_serial_deframer.md
# m_serial_deframer

Serial-to-parallel receive stage directly downstream of the 3-bit shift register: consumes the 1-bit stream it produces, one bit per clock. Detects a start bit, assembles `DATA_W` data bits LSB-first, checks the stop bit (and optionally parity), then presents the word on a one-entry valid/ready output buffer. Reports framing errors and overruns as single-cycle pulses.

## Interface
- `DATA_W`, default 8: data bits per frame, legal range 2..16.
- `clk`  input  1  rising-edge clock; all state changes on posedge.
- `reset`  input  1  synchronous, active-high reset.
- `d_in`  input  1  serial line; idle level 1; sampled every posedge.
- `data_out`  output  `DATA_W`  buffered received word; valid only while `valid`=1.
- `valid`  output  1  output buffer holds an unconsumed word.
- `ready`  input  1  consumer accepts the word at a posedge where `valid`&&`ready`.
- `busy`  output  1  1 in any state other than IDLE.
- `frame_err`  output  1  one-cycle pulse: bad stop bit or parity.
- `overrun`  output  1  one-cycle pulse: good frame dropped because buffer full.

## Operation
- Frame on `d_in`: start bit 0, `DATA_W` data bits LSB-first, [parity bit], stop bit 1. One bit per clock, no oversampling.
- States: IDLE, DATA, PARITY (only with `DESER_PARITY_EN`), STOP.
- IDLE: `d_in`=0 at posedge -> DATA, bit counter cleared; `d_in`=1 -> stay.
- DATA: shift `d_in` into bit `cnt` of the assembly register; after bit `DATA_W-1` -> PARITY if enabled, else STOP.
- PARITY: capture parity bit -> STOP.
- STOP: always -> IDLE at this edge. Frame is good if `d_in`=1 and parity matches. A bad frame pulses `frame_err`, is discarded, and leaves the buffer untouched. A stop-bit 0 is not reinterpreted as a new start bit.
- Good frame, buffer free, or freed at the same edge (`valid`&&`ready`): load `data_out`, `valid`=1.
- Good frame, buffer full and not freed this edge: `overrun` pulse; new word dropped; old word and `valid` kept.
- Pop: `valid`&&`ready` at a posedge with no load -> `valid`=0. `data_out` holds its last value.
- `ready` is ignored while `valid`=0.
- Reset values: state IDLE, counter 0, `data_out`=0, `valid`=0, `busy`=0, `frame_err`=0, `overrun`=0.
- `reset` mid-frame: the partial frame is discarded and the buffered word is lost. `reset` dominates `ready` and all line activity in the same cycle.

## Timing
- All outputs are registered; no combinational path from `d_in` or `ready` to any output.
- `busy` rises in the cycle after the edge that samples the start bit.
- Latency: `valid`, `frame_err` and `overrun` rise in the cycle after the edge that samples the stop bit.
- Minimum frame period is `DATA_W`+2 cycles (+1 with parity). Back-to-back frames are supported: a start bit may be sampled on the edge immediately after the stop-bit edge.
- Throughput: sustained one word per frame period when `ready` is held at 1.

## Configuration
- `DESER_PARITY_EN` defined: one even-parity bit follows the data bits. Good frame requires XOR of data bits and parity bit to equal 0; a mismatch pulses `frame_err`. Frame period becomes `DATA_W`+3.
- Not defined: no PARITY state and no parity check. Frame period is `DATA_W`+2.

## Test plan
- Reset then line idle at 1 for 20 cycles -> `busy`, `valid`, `frame_err`, `overrun` all 0; `data_out`=0x00.
- `DATA_W`=8, no parity, send 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) with `ready`=0 -> `valid`=1 and `data_out`=0xA5 one cycle after the stop edge, held until `ready`=1 for one cycle, then `valid`=0.
- Send 0x3C with stop bit 0 -> one `frame_err` pulse; `valid` stays 0; a following 0x81 frame is received correctly.
- `ready`=0; send 0x11 then 0x22 back-to-back -> `data_out`=0x11; `overrun` pulse after the second stop edge; 0x22 lost.
- `valid`=1 with 0x11; assert `ready` exactly on the stop edge of 0x22 -> no `overrun`; `data_out`=0x22 and `valid` stays 1.
- `reset` asserted mid-data of 0xFF, then 0x5A sent -> no output for 0xFF; 0x5A delivered. With `DESER_PARITY_EN`: 0x5A with parity 0 is accepted, and with parity 1 gives a `frame_err` pulse.
